// File: rtl/demux_tdm_1_4.sv
// demux_tdm_1_4: receive end of a 4:1 TDM link.
// Slot k of a frame carries lane k. The frame start is marked by sync on the
// slot-0 sample. Slots 0..2 are collected in shadow registers. The lanes are
// updated in one step when slot 3 arrives, so a partial frame never reaches
// the outputs.
//
// state | meaning
// ------+-------------------------------------------------------------
// HUNT  | no frame alignment; wait for an enabled sample with sync=1
// LOCK  | aligned; s is the slot expected at the next enabled sample
module demux_tdm_1_4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] y_0,
  output logic [WIDTH-1:0] y_1,
  output logic [WIDTH-1:0] y_2,
  output logic [WIDTH-1:0] y_3,
  output logic [1:0]       s,
  output logic             valid,
  output logic             locked,
  output logic             err
);

  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sh_0;
  logic [WIDTH-1:0] sh_1;
  logic [WIDTH-1:0] sh_2;

  // Slot 3 is copied straight from d to y_3 on the completing edge, so it
  // needs no shadow register of its own.

  // Frame alignment FSM, slot counter, shadow capture and lane update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
      s     <= 2'd0;
      sh_0  <= '0;
      sh_1  <= '0;
      sh_2  <= '0;
      y_0   <= '0;
      y_1   <= '0;
      y_2   <= '0;
      y_3   <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (en) begin
        case (state)
          HUNT: begin
            if (sync) begin
              sh_0  <= d;
              s     <= 2'd1;
              state <= LOCK;
            end else begin
              s <= 2'd0;
            end
          end
          LOCK: begin
            if (sync) begin
              // A marker at s!=0 is early. Restart the frame from this
              // sample and keep the lock.
              if (s != 2'd0) begin
                err <= 1'b1;
              end
              sh_0 <= d;
              s    <= 2'd1;
            end else begin
              case (s)
                2'd0: begin
                  // The slot-0 marker is missing, so alignment is lost.
                  err   <= 1'b1;
                  state <= HUNT;
                  s     <= 2'd0;
                end
                2'd1: begin
                  sh_1 <= d;
                  s    <= 2'd2;
                end
                2'd2: begin
                  sh_2 <= d;
                  s    <= 2'd3;
                end
                default: begin
                  y_0   <= sh_0;
                  y_1   <= sh_1;
                  y_2   <= sh_2;
                  y_3   <= d;
                  valid <= 1'b1;
                  s     <= 2'd0;
                end
              endcase
            end
          end
          default: begin
            state <= HUNT;
            s     <= 2'd0;
          end
        endcase
      end
    end
  end

  // locked is a direct copy of the state register, with no logic in the path.
  assign locked = (state == LOCK);

endmodule
